// File: rtl/ahb_lite_manager.sv
// rtl/ahb_lite_manager.sv - single-transfer AHB-Lite manager with pipelined address and data phases
module ahb_lite_manager #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  hsel,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic [2:0]            hsize,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata,
  output logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hresp,
  input  logic                  hready
);

  // Address-phase stage
  logic                  r_ap_valid;
  logic [ADDR_WIDTH-1:0] r_ap_addr;
  logic                  r_ap_write;
  logic [1:0]            r_ap_size;
  logic [DATA_WIDTH-1:0] r_ap_wdata;

  // Data-phase stage; r_hwdata drives the bus directly
  logic                  r_dp_valid;
  logic                  r_dp_write;
  logic [DATA_WIDTH-1:0] r_hwdata;

  // Response registers
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_error;

  logic [1:0]            w_size_clamped;
  logic                  w_complete;

  // Size 3 (doubleword) is not supported on this bus width; fold it to word.
  assign w_size_clamped = (req_size == 2'd3) ? 2'd2 : req_size;
  assign w_complete     = hready && r_dp_valid;

  assign req_ready = hready;
  assign busy      = r_ap_valid || r_dp_valid;
  assign hsel      = r_ap_valid;
  assign htrans    = r_ap_valid ? 2'b10 : 2'b00;
  assign haddr     = r_ap_addr;
  assign hwrite    = r_ap_write;
  assign hsize     = {1'b0, r_ap_size};
  assign hwdata    = r_hwdata;
  assign hburst    = 3'b000;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

  // Advance the AP->DP pipeline on every ready edge; hold everything during wait states.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ap_valid <= 1'b0;
      r_ap_addr  <= '0;
      r_ap_write <= 1'b0;
      r_ap_size  <= 2'd0;
      r_ap_wdata <= '0;
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_hwdata   <= '0;
    end else if (hready) begin
      r_dp_valid <= r_ap_valid;
      r_dp_write <= r_ap_write;
      r_hwdata   <= (r_ap_valid && r_ap_write) ? r_ap_wdata : '0;
      r_ap_valid <= req_valid;
      if (req_valid) begin
        r_ap_addr  <= req_addr;
        r_ap_write <= req_write;
        r_ap_size  <= w_size_clamped;
        r_ap_wdata <= req_wdata;
      end
    end
  end

  // Capture the subordinate's response when a data phase completes.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= w_complete;
      if (w_complete) begin
        r_rsp_error <= hresp;
        r_rsp_rdata <= (!r_dp_write && !hresp) ? hrdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// tb/tb_ahb_lite_manager.sv - directed self-checking bench for ahb_lite_manager
module tb_ahb_lite_manager;

  logic        clk;
  logic        n_rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        hsel;
  logic [3:0]  haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [2:0]  hburst;
  logic [31:0] hrdata;
  logic        hresp;
  logic        hready;

  int n_checks = 0;
  int n_errors = 0;

  ahb_lite_manager #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy), .hsel(hsel), .haddr(haddr), .htrans(htrans), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata), .hburst(hburst),
    .hrdata(hrdata), .hresp(hresp), .hready(hready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic w, input logic [3:0] a,
                         input logic [1:0] s, input logic [31:0] d);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_size  = s;
    req_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst  = 1'b0;
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = 32'h0;
    set_req(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    #22;
    // Reset state
    check_eq("rst_htrans", 32'(htrans), 32'h0);
    check_eq("rst_hsel", 32'(hsel), 32'h0);
    check_eq("rst_haddr", 32'(haddr), 32'h0);
    check_eq("rst_hwrite", 32'(hwrite), 32'h0);
    check_eq("rst_hsize", 32'(hsize), 32'h0);
    check_eq("rst_hwdata", hwdata, 32'h0);
    check_eq("rst_hburst", 32'(hburst), 32'h0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("rst_rsp_error", 32'(rsp_error), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    n_rst = 1'b1;
    tick();
    tick();
    check_eq("idle_rsp_valid", 32'(rsp_valid), 32'h0);

    // Single write
    set_req(1'b1, 1'b1, 4'h4, 2'd2, 32'hDEADBEEF);
    check_eq("wr_req_ready", 32'(req_ready), 32'h1);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    check_eq("wr_htrans", 32'(htrans), 32'h2);
    check_eq("wr_hsel", 32'(hsel), 32'h1);
    check_eq("wr_haddr", 32'(haddr), 32'h4);
    check_eq("wr_hwrite", 32'(hwrite), 32'h1);
    check_eq("wr_hsize", 32'(hsize), 32'h2);
    check_eq("wr_busy", 32'(busy), 32'h1);
    tick();
    check_eq("wr_hwdata", hwdata, 32'hDEADBEEF);
    check_eq("wr_htrans_idle", 32'(htrans), 32'h0);
    check_eq("wr_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    check_eq("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("wr_rsp_error", 32'(rsp_error), 32'h0);
    check_eq("wr_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    check_eq("wr_rsp_pulse", 32'(rsp_valid), 32'h0);
    check_eq("wr_busy_done", 32'(busy), 32'h0);

    // Read with two wait states
    set_req(1'b1, 1'b0, 4'h8, 2'd2, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    check_eq("rd_htrans", 32'(htrans), 32'h2);
    check_eq("rd_haddr", 32'(haddr), 32'h8);
    tick();
    hready = 1'b0;
    check_eq("rd_req_ready_w1", 32'(req_ready), 32'h0);
    check_eq("rd_haddr_w1", 32'(haddr), 32'h8);
    tick();
    check_eq("rd_haddr_w2", 32'(haddr), 32'h8);
    check_eq("rd_hwrite_w2", 32'(hwrite), 32'h0);
    check_eq("rd_rsp_w2", 32'(rsp_valid), 32'h0);
    check_eq("rd_busy_w2", 32'(busy), 32'h1);
    tick();
    check_eq("rd_rsp_w3", 32'(rsp_valid), 32'h0);
    hready = 1'b1;
    hrdata = 32'h12345678;
    tick();
    hrdata = 32'h0;
    check_eq("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    check_eq("rd_rsp_error", 32'(rsp_error), 32'h0);
    tick();
    check_eq("rd_rsp_pulse", 32'(rsp_valid), 32'h0);

    // Back-to-back write then read
    set_req(1'b1, 1'b1, 4'h0, 2'd0, 32'h000000A5);
    tick();
    check_eq("b2b_wr_hwrite", 32'(hwrite), 32'h1);
    check_eq("b2b_wr_hsize", 32'(hsize), 32'h0);
    set_req(1'b1, 1'b0, 4'h0, 2'd0, 32'h0);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    check_eq("b2b_rd_htrans", 32'(htrans), 32'h2);
    check_eq("b2b_rd_hwrite", 32'(hwrite), 32'h0);
    check_eq("b2b_overlap_hwdata", hwdata, 32'h000000A5);
    hrdata = 32'h000000A5;
    tick();
    check_eq("b2b_rsp1_valid", 32'(rsp_valid), 32'h1);
    check_eq("b2b_rsp1_rdata", rsp_rdata, 32'h0);
    check_eq("b2b_rd_hwdata", hwdata, 32'h0);
    tick();
    hrdata = 32'h0;
    check_eq("b2b_rsp2_valid", 32'(rsp_valid), 32'h1);
    check_eq("b2b_rsp2_rdata", rsp_rdata, 32'h000000A5);
    tick();
    check_eq("b2b_rsp_end", 32'(rsp_valid), 32'h0);

    // Error response on a read, with a write queued behind it
    set_req(1'b1, 1'b0, 4'hC, 2'd2, 32'h0);
    tick();
    set_req(1'b1, 1'b1, 4'h4, 2'd2, 32'h00000011);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    hresp  = 1'b1;
    hready = 1'b0;
    hrdata = 32'hFFFFFFFF;
    check_eq("err_req_ready", 32'(req_ready), 32'h0);
    check_eq("err_ap_htrans", 32'(htrans), 32'h2);
    check_eq("err_ap_haddr", 32'(haddr), 32'h4);
    check_eq("err_ap_hwrite", 32'(hwrite), 32'h1);
    tick();
    hready = 1'b1;
    check_eq("err_ap_haddr_hold", 32'(haddr), 32'h4);
    check_eq("err_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    hresp  = 1'b0;
    hrdata = 32'h0;
    check_eq("err_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("err_rsp_error", 32'(rsp_error), 32'h1);
    check_eq("err_rsp_rdata", rsp_rdata, 32'h0);
    check_eq("err_next_hwdata", hwdata, 32'h00000011);
    tick();
    check_eq("err_wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("err_wr_rsp_error", 32'(rsp_error), 32'h0);
    tick();

    // Size 3 clamps to word
    set_req(1'b1, 1'b1, 4'h2, 2'd3, 32'h0000CAFE);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    check_eq("sz3_hsize", 32'(hsize), 32'h2);
    tick();
    tick();
    check_eq("sz3_rsp_valid", 32'(rsp_valid), 32'h1);
    tick();

    // Reset during a stalled data phase
    set_req(1'b1, 1'b1, 4'h6, 2'd2, 32'h55AA55AA);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    tick();
    hready = 1'b0;
    check_eq("mr_hwdata_pre", hwdata, 32'h55AA55AA);
    tick();
    n_rst = 1'b0;
    #1;
    check_eq("mr_htrans", 32'(htrans), 32'h0);
    check_eq("mr_hsel", 32'(hsel), 32'h0);
    check_eq("mr_haddr", 32'(haddr), 32'h0);
    check_eq("mr_hwdata", hwdata, 32'h0);
    check_eq("mr_busy", 32'(busy), 32'h0);
    check_eq("mr_rsp_valid", 32'(rsp_valid), 32'h0);
    hready = 1'b1;
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("mr_no_rsp_%0d", i), 32'(rsp_valid), 32'h0);
      check_eq($sformatf("mr_idle_%0d", i), 32'(htrans), 32'h0);
    end
    set_req(1'b1, 1'b1, 4'h1, 2'd1, 32'h0000BEEF);
    tick();
    set_req(1'b0, 1'b0, 4'h0, 2'd0, 32'h0);
    check_eq("mr_new_haddr", 32'(haddr), 32'h1);
    check_eq("mr_new_hsize", 32'(hsize), 32'h1);
    tick();
    check_eq("mr_new_hwdata", hwdata, 32'h0000BEEF);
    tick();
    check_eq("mr_new_rsp_valid", 32'(rsp_valid), 32'h1);
    check_eq("mr_new_rsp_error", 32'(rsp_error), 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_lite_manager.md
# ahb_lite_manager

AHB-Lite manager (initiator) that turns a simple command/response interface into single, non-burst AHB-Lite transfers. It is the bus-driving counterpart to the USB AHB-Lite subordinate. The block serves as the on-chip engine for firmware-model and BIST traffic, and as the bench driver for the USB endpoint's register and FIFO space. Address and data phases are pipelined, so back-to-back commands issue one per cycle when the subordinate inserts no wait states.

## Interface
- ADDR_WIDTH, 4: haddr / req_addr width
- DATA_WIDTH, 32: hwdata / hrdata / req_wdata / rsp_rdata width
- Clocking: one clock; reset is asynchronous and active-low (clk, n_rst).
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- req_valid  in  1  command present
- req_ready  out  1  command accepted at this edge when req_valid is also high; combinational, equals hready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  transfer address, passed unchanged, no alignment check
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is clamped to 2
- req_wdata  in  DATA_WIDTH  write data, captured with the command
- rsp_valid  out  1  one-cycle pulse: one transfer completed
- rsp_rdata  out  DATA_WIDTH  hrdata captured at completion; holds 0 for writes
- rsp_error  out  1  hresp captured at completion
- busy  out  1  an address phase or a data phase is outstanding
- hsel  out  1  high while an address phase is valid
- haddr  out  ADDR_WIDTH  address-phase address
- htrans  out  2  IDLE (00) or NONSEQ (10) only
- hsize  out  3  {1'b0, clamped req_size}
- hwrite  out  1  address-phase direction
- hwdata  out  DATA_WIDTH  data-phase write data
- hburst  out  3  constant 000 (SINGLE)
- hrdata  in  DATA_WIDTH  subordinate read data
- hresp  in  1  subordinate error response
- hready  in  1  subordinate ready (hreadyout of the single subordinate)

## Operation
- Two register stages:
  - Address-phase (AP): valid, addr, write, size, wdata.
  - Data-phase (DP): valid, write, wdata.
- At each rising edge with hready=1:
  - DP <= AP. hwdata <= the AP wdata; it is 0 if the AP entry is a read or is invalid.
  - If req_valid=1, AP loads the command. Otherwise AP.valid <= 0.
- At an edge with hready=0, AP and DP hold. All AHB outputs stay stable, as the protocol requires.
- Completion is an edge with hready=1 and DP.valid=1. On the next cycle:
  - rsp_valid=1.
  - rsp_error=hresp sampled at that edge.
  - rsp_rdata=hrdata if the transfer was a read and hresp=0; otherwise 0.
- Error handling: during the first error cycle (hresp=1, hready=0) the manager does not cancel the pending AP transfer, which AHB-Lite permits. The next transfer proceeds normally.
- htrans = NONSEQ when AP.valid, else IDLE. hsel = AP.valid.
- busy = AP.valid | DP.valid.
- Responses return in command order, exactly one per accepted command.

## Timing
- Reset values:
  - htrans=00, hsel=0, haddr=0, hwrite=0, hsize=0, hwdata=0, hburst=000.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, busy=0.
- Accept at edge E0 → address phase in cycle E0..E1 → data phase E1..E2 (zero-wait) → rsp_valid in cycle E2..E3. Latency is 2 edges from acceptance to rsp_valid.
- Each wait state adds one cycle to the stalled phase and to every transfer queued behind it.
- Throughput is 1 transfer/cycle with req_valid held high and hready=1.
- req_ready low (hready=0): the command is not taken and the requester must hold it.
- Reset asserted mid-transfer: all stages clear immediately. The in-flight transfer gets no response. The first cycle after reset release is IDLE.
- Idle with hready=1: DP shifts in IDLE and no rsp_valid is produced.

## Test plan
- Single write: addr=4, size=2, wdata=0xDEADBEEF, hready=1.
  - htrans=10, haddr=4, hwrite=1 in cycle 1; hwdata=0xDEADBEEF in cycle 2.
  - rsp_valid, rsp_error=0 in cycle 3.
- Read with 2 wait states: addr=8, subordinate holds hready=0 for 2 cycles, then returns hrdata=0x12345678.
  - Address outputs stable through the wait states; req_ready=0 during them.
  - rsp_rdata=0x12345678 one cycle after hready rises.
- Back-to-back: write 0xA5 to addr 0 (size 0), then read addr 0, on consecutive cycles.
  - Read's address phase overlaps the write's data phase.
  - Two rsp_valid pulses on consecutive cycles, in order.
- Error: read addr 0xC; subordinate drives hresp=1,hready=0 then hresp=1,hready=1.
  - The next queued write still issues.
  - rsp_error=1 with rsp_rdata=0, then rsp_error=0 for the write.
- req_size=3: hsize=010.
- Reset mid-operation: assert n_rst low during a stalled data phase.
  - All outputs are at reset values while n_rst is low.
  - No rsp_valid after release.
  - A new command completes normally.
